bcd4d_to_bin_seq: RTL

Sequential 4-digit BCD to 12-bit binary converter, the inverse of the terminal's binary-to-BCD display path. Keypad and price-entry logic produce packed BCD values. This block converts them to binary for the arithmetic and price-table units. The 16'hFFFF blank sentinel maps back to 12'hFFF, and the block flags invalid digits and values above 4095. It uses an iterative reverse double-dabble datapath with a valid/ready handshake on both sides.

---
 rtl/bcd4d_to_bin_seq_pkg.sv | 14 +
 rtl/bcd4d_to_bin_seq_nibble_adjust.sv | 8 +
 rtl/bcd4d_to_bin_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd4d_to_bin_seq_pkg.sv
// Shared constants and state encoding for the 4-digit BCD to binary converter.
package bcd4d_to_bin_seq_pkg;
  localparam logic [15:0] BCD_SENTINEL = 16'hFFFF;
  localparam logic [11:0] BIN_SENTINEL = 12'hFFF;
  localparam int          NUM_SHIFTS   = 14;
  localparam logic [3:0]  LAST_CNT     = 4'(NUM_SHIFTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/bcd4d_to_bin_seq_nibble_adjust.sv
// Reverse double-dabble digit correction: a shifted nibble of 8 or more
// picked up a half-ten from the digit above and must lose 3.
module bcd_nibble_adjust (
  input  logic [3:0] x,
  output logic [3:0] y
);
  assign y = (x >= 4'd8) ? (x - 4'd3) : x;
endmodule

// File: rtl/bcd4d_to_bin_seq.sv
// Iterative 4-digit packed BCD to 12-bit binary converter with valid/ready
// handshakes, blank-sentinel passthrough and digit/overflow flagging.
module bcd4d_to_bin_seq
  import bcd4d_to_bin_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bcd_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] bin_out,
  output logic        out_blank,
  output logic        err_digit,
  output logic        err_ovf
);
  state_t      state, state_nx;
  logic [15:0] bcd_reg;
  logic [13:0] bin_reg;
  logic [3:0]  cnt;
  logic [29:0] shifted;
  logic [15:0] bcd_adj;
  logic        accept, handshake, is_blank, is_bad;

  function automatic logic has_bad_digit(input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign is_blank  = (bcd_in == BCD_SENTINEL);
  assign is_bad    = has_bad_digit(bcd_in);

  // Shift the combined register right, then correct each BCD digit.
  assign shifted = {bcd_reg, bin_reg} >> 1;

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .x (shifted[14 + 4*g +: 4]),
      .y (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (is_blank || is_bad) ? DONE : SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nx = FINISH;
      FINISH:  state_nx = DONE;
      DONE:    if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and result registers; out_valid rises one edge after DONE is entered
  // on early exit, and on the FINISH edge for numeric conversions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      out_blank <= 1'b0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_blank) begin
              bin_out   <= BIN_SENTINEL;
              out_blank <= 1'b1;
            end else if (is_bad) begin
              bin_out   <= BIN_SENTINEL;
              err_digit <= 1'b1;
            end
          end
        end
        SHIFT: cnt <= cnt + 4'd1;
        FINISH: begin
          out_valid <= 1'b1;
          if (bin_reg[13:12] != 2'b00) begin
            bin_out <= BIN_SENTINEL;
            err_ovf <= 1'b1;
          end else begin
            bin_out <= bin_reg[11:0];
          end
        end
        DONE: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_blank <= 1'b0;
            err_digit <= 1'b0;
            err_ovf   <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Conversion datapath carries no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      bcd_reg <= bcd_in;
      bin_reg <= '0;
    end else if (state == SHIFT) begin
      bcd_reg <= bcd_adj;
      bin_reg <= shifted[13:0];
    end
  end
endmodule
